// File: rtl/led7_pkg.sv
// rtl/led7_pkg.sv - segment type and glyph constants for the seven-segment decoder
package led7_pkg;

  typedef logic [6:0] seg7_t;

  // Bit order is {g,f,e,d,c,b,a}, active-high.
  localparam seg7_t SEG_0     = 7'h3F;
  localparam seg7_t SEG_1     = 7'h06;
  localparam seg7_t SEG_2     = 7'h5B;
  localparam seg7_t SEG_3     = 7'h4F;
  localparam seg7_t SEG_4     = 7'h66;
  localparam seg7_t SEG_5     = 7'h6D;
  localparam seg7_t SEG_6     = 7'h7D;
  localparam seg7_t SEG_7     = 7'h07;
  localparam seg7_t SEG_8     = 7'h7F;
  localparam seg7_t SEG_9     = 7'h6F;
  localparam seg7_t SEG_A     = 7'h77;
  localparam seg7_t SEG_B     = 7'h7C;
  localparam seg7_t SEG_C     = 7'h39;
  localparam seg7_t SEG_D     = 7'h5E;
  localparam seg7_t SEG_E     = 7'h79;
  localparam seg7_t SEG_F     = 7'h71;
  localparam seg7_t SEG_DASH  = 7'h40;
  localparam seg7_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/led7_seg_lut.sv
// rtl/led7_seg_lut.sv - combinational nibble to segment lookup; LED7_HEX_EN selects hex glyphs over dash
module led7_seg_lut
  import led7_pkg::*;
(
  input  logic [3:0] in,
  output seg7_t      seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (in)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
`ifdef LED7_HEX_EN
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
`else
      // Non-decimal values render as a dash when hex glyphs are disabled.
      4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: seg = SEG_DASH;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/led7_decoder.sv
// rtl/led7_decoder.sv - registered seven-segment digit decoder with blanking; glyph set set by LED7_HEX_EN
module led7_decoder
  import led7_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       on,
  input  logic [3:0] in,
  output logic [6:0] out
);

  seg7_t lut_seg;

  led7_seg_lut u_lut (
    .in  (in),
    .seg (lut_seg)
  );

  // Reset and blanking both force the dark pattern; the decode only reaches
  // the pins when the digit is enabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      out <= SEG_BLANK;
    end else if (!on) begin
      out <= SEG_BLANK;
    end else begin
      out <= lut_seg;
    end
  end

endmodule

// File: tb/tb_led7_decoder.sv
// tb/tb_led7_decoder.sv - self-checking bench for led7_decoder with a glyph-table reference model
module tb_led7_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       on;
  logic [3:0] in;
  logic [6:0] out;

  int n_total = 0;
  int n_pass  = 0;

  logic [6:0] glyph [16];
  logic [6:0] exp_out;
  logic       mdl_valid = 1'b0;

  led7_decoder dut (
    .clk (clk),
    .rst (rst),
    .on  (on),
    .in  (in),
    .out (out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    n_total++;
    if (got === want) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %02h want %02h at %0t", name, got, want, $time);
    end
  endtask

  // Reference: the display shows the glyph for the value seen at the last
  // edge, or nothing if reset or blanked at that edge.
  always @(posedge clk) begin
    if (rst === 1'b1 || on === 1'b0) exp_out <= 7'h00;
    else                             exp_out <= glyph[in];
    mdl_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (mdl_valid) check("model", out, exp_out);
  end

  task automatic step(input logic r, input logic o, input logic [3:0] v);
    rst = r;
    on  = o;
    in  = v;
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [6:0] sweep_exp [10];
  logic [6:0] hex_exp   [3];
  logic [3:0] hex_in    [3];

  initial begin
    glyph[0]  = 7'h3F; glyph[1]  = 7'h06; glyph[2]  = 7'h5B; glyph[3]  = 7'h4F;
    glyph[4]  = 7'h66; glyph[5]  = 7'h6D; glyph[6]  = 7'h7D; glyph[7]  = 7'h07;
    glyph[8]  = 7'h7F; glyph[9]  = 7'h6F;
`ifdef LED7_HEX_EN
    glyph[10] = 7'h77; glyph[11] = 7'h7C; glyph[12] = 7'h39;
    glyph[13] = 7'h5E; glyph[14] = 7'h79; glyph[15] = 7'h71;
    hex_exp[0] = 7'h71; hex_exp[1] = 7'h79; hex_exp[2] = 7'h77;
`else
    for (int i = 10; i < 16; i++) glyph[i] = 7'h40;
    hex_exp[0] = 7'h40; hex_exp[1] = 7'h40; hex_exp[2] = 7'h40;
`endif
    hex_in[0] = 4'd15; hex_in[1] = 4'd14; hex_in[2] = 4'd10;
    sweep_exp[0] = 7'h6F; sweep_exp[1] = 7'h7F; sweep_exp[2] = 7'h07;
    sweep_exp[3] = 7'h7D; sweep_exp[4] = 7'h6D; sweep_exp[5] = 7'h66;
    sweep_exp[6] = 7'h4F; sweep_exp[7] = 7'h5B; sweep_exp[8] = 7'h06;
    sweep_exp[9] = 7'h3F;

    rst = 1'b1; on = 1'b1; in = 4'd8;
    @(negedge clk);

    step(1'b1, 1'b1, 4'd8); check("reset_hold0", out, 7'h00);
    step(1'b1, 1'b1, 4'd8); check("reset_hold1", out, 7'h00);
    step(1'b0, 1'b1, 4'd8); check("reset_release", out, 7'h7F);

    for (int k = 0; k < 10; k++) begin
      step(1'b0, 1'b1, 4'(9 - k));
      check("sweep", out, sweep_exp[k]);
    end

    step(1'b0, 1'b0, 4'd2);  check("blank_2", out, 7'h00);
    step(1'b0, 1'b0, 4'd10); check("blank_10", out, 7'h00);
    step(1'b0, 1'b1, 4'd2);  check("unblank_2", out, 7'h5B);

    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, hex_in[k]);
      check("code_10_15", out, hex_exp[k]);
    end

    step(1'b0, 1'b1, 4'd3); check("simul_pre", out, 7'h4F);
    step(1'b0, 1'b0, 4'd7); check("simul_post", out, 7'h00);
    step(1'b0, 1'b0, 4'd7); check("simul_hold", out, 7'h00);

    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 4'(9 - k));
      check("sweep2", out, sweep_exp[k]);
    end
    step(1'b1, 1'b1, 4'd5); check("mid_reset", out, 7'h00);
    step(1'b0, 1'b1, 4'd5); check("mid_resume", out, 7'h6D);
    step(1'b0, 1'b1, 4'd4); check("mid_next", out, 7'h66);

    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
